matrix_column_scanner: RTL
==========================

MATRIX_COLUMN_SCANNER -- requirements
Module: matrix_column_scanner

Interface
REQ-001 SHALL have parameter: COLS, 5, number of matrix columns driven (>=2).
REQ-002 SHALL have parameter: DWELL, 1000, clock cycles each scan step is held (>=1).
REQ-003 SHALL have port: clock  input  1  sole clock, rising-edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: enable  input  1  scan run request.
REQ-006 SHALL have port: mirror  input  1  mode request; 1 = Y-axis mirrored scan, 0 = linear scan.
REQ-007 SHALL have port: column  output  COLS  active-high column drive, bit 0 = leftmost column.
REQ-008 SHALL have port: step  output  $clog2(COLS)  current ring position.
REQ-009 SHALL have port: frame_start  output  1  one-cycle pulse on the first cycle of step 0.

Function
REQ-010 SHALL implement states IDLE, SCAN, BLANK; all outputs registered.
REQ-011 SHALL use ring length R = (COLS+1)/2 when latched mode is mirrored, R = COLS when linear.
REQ-012 SHALL drive, in SCAN, column[c]=1 iff step == c (linear) or step == min(c, COLS-1-c) (mirrored); all other bits 0.
REQ-013 SHALL drive column = 0 in IDLE and BLANK.
REQ-014 SHALL, in IDLE with enable=1 at an edge, enter SCAN with step=0, latch mirror, assert frame_start, and drive the step-0 pattern from that edge.
REQ-015 SHALL hold each step for exactly DWELL cycles using a dwell counter counting 0..DWELL-1.
REQ-016 SHALL advance step at dwell terminal count; step wraps from R-1 to 0.
REQ-017 SHALL latch mirror and pulse frame_start only on wrap to step 0; mode changes mid-frame take effect at next frame.
REQ-018 SHALL, with DWELL=1, advance step every cycle with no gap.
REQ-019 SHALL, when enable=0 at any edge in SCAN or BLANK, enter IDLE, clear column, step, dwell counter; re-enable restarts at step 0 with frame_start.
REQ-020 SHALL never assert more than two column bits, and exactly one in linear mode.
REQ-021 SHALL, for odd COLS in mirrored mode, drive only the centre column on step R-1.

Reset
REQ-022 SHALL, on reset=1 at an edge, set state IDLE, column=0, step=0, frame_start=0, dwell counter=0, latched mode=0, overriding enable.
REQ-023 SHALL honour reset mid-scan with outputs zero after that edge.

Configuration
REQ-024 SHALL, with MATRIX_SCAN_BLANKING_EN defined, enter BLANK for exactly one cycle (column=0, frame_start=0) after each step's dwell, then SCAN with the next step; step output shows the next step during BLANK.
REQ-025 SHALL, without MATRIX_SCAN_BLANKING_EN, never enter BLANK; steps are back-to-back.

Structure
REQ-026 SHALL take the scan-state enum and a ring-length function (COLS, mode) from shared package matrix_pkg.
REQ-027 SHALL place the dwell counter in sub-module matrix_dwell_prescaler (parameter DWELL, inputs clock/reset/clear, output terminal-count pulse).

Verification
REQ-028 SHALL cover: COLS=5, DWELL=3, mirror=1, enable after reset -> column 10001 (bit4..bit0), 01010, 00100, each 3 cycles, frame_start every 9 cycles.
REQ-029 SHALL cover: COLS=5, DWELL=3, mirror=0 -> 00001, 00010, 00100, 01000, 10000, each 3 cycles, period 15.
REQ-030 SHALL cover: COLS=4, DWELL=1, mirror=1 -> 1001, 0110 alternating every cycle; mirror toggled to 0 at step 0 -> change applied only after next wrap.
REQ-031 SHALL cover: enable dropped at step 1 cycle 2 -> column 0 next edge; enable re-raised -> step 0 pattern plus frame_start.
REQ-032 SHALL cover: reset asserted mid-step 2 with enable=1 -> all outputs 0 after edge, IDLE, scan restarts on next enable edge.
REQ-033 SHALL cover: MATRIX_SCAN_BLANKING_EN defined, COLS=5, DWELL=3, mirror=1 -> one 00000 cycle after each step, frame period 12 cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix column scanner.
// Holds the scan-state enum and the ring-length rule used by the scanner.
package matrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } scan_state_e;

    // Mirrored scans fold the matrix about its vertical axis, so only half the ring is needed.
    function automatic int ring_len(input int cols, input logic mirrored);
        return mirrored ? (cols + 1) / 2 : cols;
    endfunction

endpackage

// File: rtl/matrix_dwell_prescaler.sv
// Dwell counter for the column scanner: counts 0..DWELL-1 and flags the terminal count.
// The count restarts from 0 whenever clear is high.
module matrix_dwell_prescaler #(
    parameter int DWELL = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tc
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] count;

    assign tc = (count == LAST);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clear || tc) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/matrix_column_scanner.sv
// Column drive sequencer for an LED/key matrix with linear or Y-mirrored scan order.
// Define MATRIX_SCAN_BLANKING_EN to insert a one-cycle all-off gap between steps.
module matrix_column_scanner
    import matrix_pkg::*;
#(
    parameter int COLS  = 5,
    parameter int DWELL = 1000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mirror,
    output logic [COLS-1:0]          column,
    output logic [$clog2(COLS)-1:0]  step,
    output logic                     frame_start
);

    localparam int STEP_W = $clog2(COLS);

    scan_state_e       state_q, state_d;
    logic              mode_q, mode_d;
    logic [STEP_W-1:0] step_d, step_next, last_step;
    logic [COLS-1:0]   column_d;
    logic              frame_start_d;
    logic              dwell_clear, dwell_tc, wrap;

    // Column c lights on step c, or on the step of its mirror partner when folded.
    function automatic logic [COLS-1:0] column_pattern(input logic [STEP_W-1:0] s,
                                                        input logic mirrored);
        logic [COLS-1:0] pat;
        pat = '0;
        for (int c = 0; c < COLS; c++) begin
            int target;
            target = (mirrored && (COLS - 1 - c < c)) ? COLS - 1 - c : c;
            pat[c] = (int'(s) == target);
        end
        return pat;
    endfunction

    assign dwell_clear = !enable || (state_q != SCAN);

    matrix_dwell_prescaler #(.DWELL(DWELL)) u_dwell (
        .clock (clock),
        .reset (reset),
        .clear (dwell_clear),
        .tc    (dwell_tc)
    );

    assign last_step = STEP_W'(ring_len(COLS, mode_q) - 1);
    assign wrap      = (step == last_step);
    assign step_next = wrap ? '0 : step + STEP_W'(1);

    // NOTE: every variable gets a default before the case, so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        step_d        = step;
        mode_d        = mode_q;
        frame_start_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d       = SCAN;
                    step_d        = '0;
                    mode_d        = mirror;
                    frame_start_d = 1'b1;
                end
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else if (dwell_tc) begin
                    step_d = step_next;
`ifdef MATRIX_SCAN_BLANKING_EN
                    state_d = BLANK;
`else
                    if (wrap) begin
                        mode_d        = mirror;
                        frame_start_d = 1'b1;
                    end
`endif
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_d = IDLE;
                    step_d  = '0;
                end else begin
                    state_d = SCAN;
                    // Step 0 is only ever reached through a wrap, so this opens a new frame.
                    if (step == '0) begin
                        mode_d        = mirror;
                        frame_start_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = '0;
            end
        endcase

        column_d = (state_d == SCAN) ? column_pattern(step_d, mode_d) : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            step        <= '0;
            column      <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            step        <= step_d;
            column      <= column_d;
            frame_start <= frame_start_d;
        end
    end

endmodule
